input_port_buffered: RTL and testbench

Parametrised mesh-router input port: it accepts flits from one link, buffers them in a FIFO, and XY-routes each packet to one of five output ports with wormhole switching. The route is computed on the head flit and held until the tail flit leaves. It sits between an incoming link and the router crossbar; each crossbar input is served by one instance. Unlike the previous combinational route-and-demux port, this block adds buffering, valid/ready handshakes and packet-level route locking.

---
 rtl/noc_pkg.sv | 49 ++++
 rtl/flit_fifo.sv | 68 ++++++
 rtl/input_port_buffered.sv | 131 +++++++++++++
 tb/tb_input_port_buffered.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Purpose: shared flit-type, port-index, FSM-state and XY-routing definitions for mesh router ports.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package noc_pkg;

  // Flit type field, taken from the two MSBs of every flit
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  // Output port indices
  localparam int NUM_PORTS = 5;
  typedef logic [2:0] port_idx_t;
  localparam port_idx_t PORT_LOCAL = 3'd0;
  localparam port_idx_t PORT_NORTH = 3'd1;
  localparam port_idx_t PORT_EAST  = 3'd2;
  localparam port_idx_t PORT_SOUTH = 3'd3;
  localparam port_idx_t PORT_WEST  = 3'd4;

  // Coordinates are zero-extended to this width before comparison,
  // so X_BITS/Y_BITS up to COORD_W are supported.
  localparam int COORD_W = 8;
  typedef logic [COORD_W-1:0] coord_t;

  // Route/lock FSM: IDLE waits for a head, BUSY follows the held route until the tail
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally
  function automatic port_idx_t xy_route(input coord_t rx, input coord_t ry,
                                         input coord_t dx, input coord_t dy);
    port_idx_t p;
    p = PORT_LOCAL;
    if (dx > rx)      p = PORT_EAST;
    else if (dx < rx) p = PORT_WEST;
    else if (dy > ry) p = PORT_NORTH;
    else if (dy < ry) p = PORT_SOUTH;
    return p;
  endfunction

  // Port index to one-hot request vector
  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t p);
    return NUM_PORTS'(1) << p;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Purpose: synchronous FIFO for flits with full/empty/count status, power-of-2 depth.
// Latency: a word pushed at edge N appears on pop_dat in cycle N+1 if the FIFO was empty.
// Backpressure: push ignored while full (no bypass), pop ignored while empty.
module flit_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers (wrap naturally at power-of-2 depth) and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage contents are not reset, only the bookkeeping
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/input_port_buffered.sv
// Purpose: buffered mesh-router input port; XY-routes packets with wormhole route locking (optional PORT_BLOCK_EN ingress stall).
// Latency: flit pushed at edge N is presented on out_flit/out_valid in cycle N+1 when it is at the FIFO front.
// Backpressure: in_ready = !full (&& !port_block); output holds flit/request stable while the selected out_ready is low.
module input_port_buffered
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int X_BITS     = 2,
  parameter int Y_BITS     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [X_BITS-1:0]     router_x,
  input  logic [Y_BITS-1:0]     router_y,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
`ifdef PORT_BLOCK_EN
  input  logic                  port_block,
`endif
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic [NUM_PORTS-1:0]  out_valid,
  input  logic [NUM_PORTS-1:0]  out_ready,
  output logic                  err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [FLIT_WIDTH-1:0] front;
  logic [1:0]            front_type;
  logic                  front_is_head;
  port_idx_t             front_route;
  logic [NUM_PORTS-1:0]  req;

  state_t    state_q,      state_d;
  port_idx_t held_route_q, held_route_d;
  logic      err_q,        err_d;

  // Occupancy is only needed for debug visibility; full/empty drive the logic.
  logic unused_count;
  assign unused_count = ^fifo_count;

`ifdef PORT_BLOCK_EN
  assign in_ready = !reset && !fifo_full && !port_block;
`else
  assign in_ready = !reset && !fifo_full;
`endif
  assign fifo_push = in_valid && in_ready;

  flit_fifo #(
    .WIDTH (FLIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (in_flit),
    .pop      (fifo_pop),
    .pop_dat  (front),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Head decode and route are purely combinational on the FIFO front entry
  assign front_type    = front[FLIT_WIDTH-1:FLIT_WIDTH-2];
  assign front_is_head = (front_type == FLIT_HEAD) || (front_type == FLIT_SINGLE);
  assign front_route   = xy_route(COORD_W'(router_x), COORD_W'(router_y),
                                  COORD_W'(front[X_BITS-1:0]),
                                  COORD_W'(front[X_BITS+Y_BITS-1:X_BITS]));
  assign out_flit      = front;
  assign err           = err_q;

  // Route/lock FSM: request, pop, drop of stray flits and error detection
  always_comb begin
    state_d      = state_q;
    held_route_d = held_route_q;
    err_d        = err_q;
    req          = '0;
    fifo_pop     = 1'b0;
    if (!reset && !fifo_empty) begin
      unique case (state_q)
        ST_IDLE: begin
          if (front_is_head) begin
            req = port_onehot(front_route);
            if (|(req & out_ready)) begin
              fifo_pop = 1'b1;
              if (front_type == FLIT_HEAD) begin
                held_route_d = front_route;
                state_d      = ST_BUSY;
              end
            end
          end else begin
            // Body/tail with no open packet: discard without requesting
            fifo_pop = 1'b1;
            err_d    = 1'b1;
          end
        end
        ST_BUSY: begin
          req = port_onehot(held_route_q);
          // A new head inside a packet is carried as payload on the locked route
          if (front_is_head) err_d = 1'b1;
          if (|(req & out_ready)) begin
            fifo_pop = 1'b1;
            if (front_type == FLIT_TAIL) state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
    out_valid = req;
  end

  // FSM, held route and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      held_route_q <= PORT_LOCAL;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_route_q <= held_route_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_input_port_buffered.sv
module tb_input_port_buffered;

  localparam int FW    = 32;
  localparam int XB    = 2;
  localparam int YB    = 2;
  localparam int DEPTH = 4;
  localparam int RX    = 1;
  localparam int RY    = 1;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready;
  logic          err;
`ifdef PORT_BLOCK_EN
  logic          port_block;
`endif

  logic [4:0] rdy_force;
  logic [4:0] rdy_rand;
  logic       rdy_use_rand;
  assign out_ready = rdy_use_rand ? rdy_rand : rdy_force;

  always #5 clk = ~clk;

  input_port_buffered #(
    .FLIT_WIDTH (FW),
    .X_BITS     (XB),
    .Y_BITS     (YB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .router_x   (2'(RX)),
    .router_y   (2'(RY)),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
`ifdef PORT_BLOCK_EN
    .port_block (port_block),
`endif
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // ---------------- reference model (packet level) ----------------
  typedef struct {
    logic [FW-1:0] flit;
    logic [4:0]    port;
  } exp_t;

  exp_t       sb[$];
  bit         m_in_pkt;
  logic [4:0] m_held;
  bit         m_err;

  function automatic logic [4:0] ref_route(input int dx, input int dy);
    if (dx > RX) return 5'b00100;
    if (dx < RX) return 5'b10000;
    if (dy > RY) return 5'b00010;
    if (dy < RY) return 5'b01000;
    return 5'b00001;
  endfunction

  function automatic void model_reset();
    sb.delete();
    m_in_pkt = 0;
    m_held   = 5'b00001;
    m_err    = 0;
  endfunction

  function automatic void model_accept(input logic [FW-1:0] f);
    logic [1:0] t;
    logic [4:0] p;
    exp_t       e;
    t = f[FW-1:FW-2];
    if (!m_in_pkt) begin
      if (t == T_HEAD || t == T_SINGLE) begin
        p = ref_route(int'(f[XB-1:0]), int'(f[XB+YB-1:XB]));
        e.flit = f; e.port = p; sb.push_back(e);
        if (t == T_HEAD) begin m_in_pkt = 1; m_held = p; end
      end else begin
        m_err = 1;
      end
    end else begin
      e.flit = f; e.port = m_held; sb.push_back(e);
      if (t == T_TAIL) m_in_pkt = 0;
      if (t == T_HEAD || t == T_SINGLE) m_err = 1;
    end
  endfunction

  // ---------------- monitor ----------------
  logic [4:0]    pv;
  logic [FW-1:0] pf;
  bit            prev_stall = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (in_valid && in_ready) model_accept(in_flit);
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'(pv));
        chk("hold_flit", 64'(out_flit), 64'(pf));
      end
      if (out_valid != 5'b0) chk("onehot", 64'($onehot(out_valid)), 64'(1));
      if ((out_valid & out_ready) != 5'b0) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_flit: got 0x%0h on ports 0x%0h, expected none", out_flit, out_valid);
        end else begin
          e = sb.pop_front();
          chk("out_flit", 64'(out_flit), 64'(e.flit));
          chk("out_port", 64'(out_valid), 64'(e.port));
        end
      end
      prev_stall = (out_valid != 5'b0) && ((out_valid & out_ready) == 5'b0);
      pv = out_valid;
      pf = out_flit;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rdy_rand = 5'($urandom);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int dx, input int dy, input int pl);
    return {t, 26'(pl), 2'(dy), 2'(dx)};
  endfunction

  task automatic send(input logic [FW-1:0] f);
    int n;
    bit acc;
    n = 0;
    in_flit  = f;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 500);
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: flit 0x%0h not accepted, expected acceptance", f);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin tick(); n++; end
    chk("drain_empty", 64'(sb.size()), 64'(0));
    repeat (DEPTH + 2) tick();
  endtask

  task automatic send_pkt(input int len, input bit corrupt);
    int dx, dy;
    logic [1:0] t;
    dx = int'($urandom_range(0, 3));
    dy = int'($urandom_range(0, 3));
    for (int i = 0; i < len; i++) begin
      if (len == 1)          t = T_SINGLE;
      else if (i == 0)       t = T_HEAD;
      else if (i == len - 1) t = T_TAIL;
      else                   t = T_BODY;
      if (corrupt && $urandom_range(0, 19) == 0) t = 2'($urandom);
      if ($urandom_range(0, 3) == 0) tick();
      send(mk(t, dx, dy, int'($urandom)));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [FW-1:0] f;
    logic [3:0]    pat;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_flit      = '0;
    rdy_force    = '0;
    rdy_use_rand = 1'b0;
    rdy_rand     = '0;
`ifdef PORT_BLOCK_EN
    port_block   = 1'b0;
`endif
    model_reset();
    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));

    // Single flit to (3,1): east, visible the cycle after push
    f = mk(T_SINGLE, 3, 1, 'h1234);
    send(f);
    @(negedge clk);
    chk("single_east_valid", 64'(out_valid), 64'(5'b00100));
    chk("single_east_flit", 64'(out_flit), 64'(f));
    tick();
    rdy_force = 5'b00100;
    drain();
    rdy_force = '0;

    // 4-flit packet to (1,0): south, out_ready[3] pattern 1,0,1,1,1
    send(mk(T_HEAD, 1, 0, 'h11));
    send(mk(T_BODY, 1, 0, 'h22));
    send(mk(T_BODY, 1, 0, 'h33));
    send(mk(T_TAIL, 1, 0, 'h44));
    pat = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      rdy_force = (i == 4 || pat[i]) ? 5'b01000 : 5'b00000;
      tick();
    end
    rdy_force = '0;
    chk("south_pkt_all_out", 64'(sb.size()), 64'(0));

    // Fill to full with local singles; 5th is held until a pop
    for (int i = 0; i < 4; i++) send(mk(T_SINGLE, 1, 1, 'h100 + i));
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("idle_after_tail_local", 64'(out_valid), 64'(5'b00001));
    in_flit  = mk(T_SINGLE, 1, 1, 'h104);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("full_held", 64'(in_ready), 64'(0));
    end
    tick();
    rdy_force = 5'b00001;
    tick();
    rdy_force = '0;
    @(negedge clk);
    chk("ready_after_pop", 64'(in_ready), 64'(1));
    tick();
    in_valid  = 1'b0;
    rdy_force = 5'b00001;
    drain();

    // Stray body flit in IDLE: dropped, sticky err
    rdy_force = 5'b11111;
    send(32'h0000_0005);
    repeat (3) tick();
    @(negedge clk);
    chk("drop_err", 64'(err), 64'(1));
    chk("drop_no_valid", 64'(out_valid), 64'(0));
    send(mk(T_SINGLE, 0, 1, 'h55));
    drain();
    chk("err_sticky", 64'(err), 64'(1));

    // Reset mid-packet discards buffered flits and clears err
    rdy_force = '0;
    send(mk(T_HEAD, 2, 2, 'h66));
    send(mk(T_BODY, 2, 2, 'h77));
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_err", 64'(err), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    send(mk(T_SINGLE, 1, 1, 'h88));
    @(negedge clk);
    chk("midrst_local", 64'(out_valid), 64'(5'b00001));
    tick();
    rdy_force = 5'b00001;
    drain();

    // Random well-formed traffic with random backpressure
    rdy_use_rand = 1'b1;
    for (int p = 0; p < 100; p++) send_pkt(int'($urandom_range(1, 4)), 1'b0);
    rdy_use_rand = 1'b0;
    rdy_force    = 5'b11111;
    drain();
    chk("clean_err", 64'(err), 64'(0));

    // Random traffic with occasional corrupted flit types
    rdy_use_rand = 1'b1;
    for (int p = 0; p < 100; p++) send_pkt(int'($urandom_range(1, 4)), 1'b1);
    rdy_use_rand = 1'b0;
    rdy_force    = 5'b11111;
    drain();
    chk("corrupt_err", 64'(err), 64'(m_err));

`ifdef PORT_BLOCK_EN
    // Ingress blocked, egress keeps draining
    reset = 1'b1;
    model_reset();
    tick();
    reset     = 1'b0;
    rdy_force = '0;
    send(mk(T_SINGLE, 2, 1, 'h91));
    send(mk(T_SINGLE, 0, 1, 'h92));
    port_block = 1'b1;
    @(negedge clk);
    chk("block_in_ready", 64'(in_ready), 64'(0));
    tick();
    rdy_force = 5'b11111;
    drain();
    port_block = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
